// File: rtl/fir_tap_sequencer_if.sv
// Bus between the ADC-side producer and the FIR tap sequencer.
// Carries the sample strobe/data in and the tap-sweep outputs (ROM address,
// delayed sample, MAC tap index, sweep start, overrun flag) back out.
//   master : drives adc_valid/adc_bits, observes the sweep outputs
//   slave  : the sequencer itself
interface fir_tap_sequencer_if #(
    parameter int unsigned Order_MSB = 5,
    parameter int unsigned ADC_MSB   = 11
);
    logic                     adc_valid;
    logic signed [ADC_MSB:0]  adc_bits;
    logic [Order_MSB:0]       rom_addr;
    logic signed [ADC_MSB:0]  buffer_bits;
    logic [Order_MSB:0]       address;
    logic                     sweep_start;
    logic                     overrun;

    modport master (
        output adc_valid, adc_bits,
        input  rom_addr, buffer_bits, address, sweep_start, overrun
    );

    modport slave (
        input  adc_valid, adc_bits,
        output rom_addr, buffer_bits, address, sweep_start, overrun
    );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: upstream feeder for the FIR multiply-accumulate stage.
// Holds a circular delay line of TAPS = 2^(Order_MSB+1) samples and sweeps the
// tap index continuously, presenting the coefficient ROM address, the delayed
// sample x[n-k] (aligned with the 1-cycle ROM read) and the tap index delayed
// to the MAC's timing. New samples are parked in a pending register and only
// committed on the last tap of a sweep, so every sweep sees one window.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus.adc_valid/adc_bits     sample strobe and signed sample
//   bus.rom_addr               coefficient ROM address (free-running tap k)
//   bus.buffer_bits            x[n-k] for the previous cycle's rom_addr
//   bus.address                rom_addr delayed 2 cycles, for the MAC
//   bus.sweep_start            high while rom_addr == 0
//   bus.overrun                pulse: a pending sample was overwritten
module fir_tap_sequencer #(
    parameter int unsigned Order_MSB = 5,
    parameter int unsigned ADC_MSB   = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fir_tap_sequencer_if.slave   bus
);
    localparam int unsigned IDX_W    = Order_MSB + 1;
    localparam int unsigned DATA_W   = ADC_MSB + 1;
    localparam int unsigned TAPS     = 2 ** IDX_W;
    localparam int unsigned LAST_TAP = TAPS - 1;

    logic [IDX_W-1:0]         r_rom_addr;
    logic [IDX_W-1:0]         r_addr_d1;
    logic [IDX_W-1:0]         r_address;
    logic                     r_sweep_start;
    logic signed [DATA_W-1:0] r_buffer_bits;
    logic [IDX_W-1:0]         r_head;
    logic                     r_pending;
    logic signed [DATA_W-1:0] r_pending_bits;
    logic                     r_overrun;
    logic signed [DATA_W-1:0] r_mem [TAPS];

    logic                     w_last_tap;
    logic                     w_commit;
    logic signed [DATA_W-1:0] w_commit_bits;
    logic [IDX_W-1:0]         w_wr_idx;
    logic [IDX_W-1:0]         w_rd_idx;

    // Commit decision and delay-line indexing (all modulo TAPS by wrap)
    always_comb begin
        w_last_tap    = (r_rom_addr == IDX_W'(LAST_TAP));
        w_commit      = w_last_tap & (r_pending | bus.adc_valid);
        // A strobe in the commit cycle is newer than anything pending
        w_commit_bits = bus.adc_valid ? bus.adc_bits : r_pending_bits;
        w_wr_idx      = r_head + IDX_W'(1);
        w_rd_idx      = r_head - r_rom_addr;
    end

    // Free-running tap counter, MAC-aligned index pipeline and sweep marker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr    <= '0;
            r_addr_d1     <= '0;
            r_address     <= '0;
            r_sweep_start <= 1'b0;
        end else begin
            r_rom_addr    <= r_rom_addr + IDX_W'(1);
            r_addr_d1     <= r_rom_addr;
            r_address     <= r_addr_d1;
            // rom_addr wraps to 0 on this edge when it currently sits on the last tap
            r_sweep_start <= w_last_tap;
        end
    end

    // Sample capture: newest strobe wins; overwriting an uncommitted sample flags overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending      <= 1'b0;
            r_pending_bits <= '0;
            r_overrun      <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_commit) begin
                r_pending <= 1'b0;
            end else if (bus.adc_valid) begin
                r_pending      <= 1'b1;
                r_pending_bits <= bus.adc_bits;
                r_overrun      <= r_pending;
            end
        end
    end

    // Head pointer only moves at commit, keeping each sweep's window fixed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
        end else if (w_commit) begin
            r_head <= w_wr_idx;
        end
    end

    // Delay line storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[w_wr_idx] <= w_commit_bits;
        end
    end

    // Registered read; on the last tap the read slot equals the commit slot and
    // the non-blocking write leaves the old sample visible to this read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buffer_bits <= '0;
        end else begin
            r_buffer_bits <= r_mem[w_rd_idx];
        end
    end

    assign bus.rom_addr    = r_rom_addr;
    assign bus.address     = r_address;
    assign bus.sweep_start = r_sweep_start;
    assign bus.buffer_bits = r_buffer_bits;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer: a 64-tap and an 8-tap instance share
// clk/rst_n. Stimulus pushes expected (cycle, dut, signal, value) entries; a
// negedge monitor pops and checks every entry tagged with the current cycle
// (tag -1 while in reset).
module tb_fir_tap_sequencer;
    localparam int SIG_ROM  = 0;
    localparam int SIG_ADDR = 1;
    localparam int SIG_BUF  = 2;
    localparam int SIG_SWP  = 3;
    localparam int SIG_OVR  = 4;

    typedef struct {
        int cyc;
        int dut;
        int sig;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    fir_tap_sequencer_if #(.Order_MSB(5), .ADC_MSB(11)) bus64 ();
    fir_tap_sequencer_if #(.Order_MSB(2), .ADC_MSB(11)) bus8 ();

    fir_tap_sequencer #(.Order_MSB(5), .ADC_MSB(11)) u_dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus64)
    );

    fir_tap_sequencer #(.Order_MSB(2), .ADC_MSB(11)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    // Cycles counted from reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int actual(input int dut, input int sig);
        if (dut == 0) begin
            case (sig)
                SIG_ROM:  return int'(bus64.rom_addr);
                SIG_ADDR: return int'(bus64.address);
                SIG_BUF:  return int'(bus64.buffer_bits);
                SIG_SWP:  return int'(bus64.sweep_start);
                default:  return int'(bus64.overrun);
            endcase
        end else begin
            case (sig)
                SIG_ROM:  return int'(bus8.rom_addr);
                SIG_ADDR: return int'(bus8.address);
                SIG_BUF:  return int'(bus8.buffer_bits);
                SIG_SWP:  return int'(bus8.sweep_start);
                default:  return int'(bus8.overrun);
            endcase
        end
    endfunction

    function automatic string sig_name(input int dut, input int sig);
        string d;
        d = (dut == 0) ? "t64" : "t8";
        case (sig)
            SIG_ROM:  return {d, ".rom_addr"};
            SIG_ADDR: return {d, ".address"};
            SIG_BUF:  return {d, ".buffer_bits"};
            SIG_SWP:  return {d, ".sweep_start"};
            default:  return {d, ".overrun"};
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle
    always @(negedge clk) begin
        int tag;
        int act;
        tag = rst_n ? cyc : -1;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == tag) begin
                act = actual(sb_q[i].dut, sb_q[i].sig);
                n_vec++;
                if (act != sb_q[i].val) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                             sig_name(sb_q[i].dut, sb_q[i].sig), tag, act, sb_q[i].val);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic expect_at(input int c, input int d, input int s, input int v);
        exp_t e;
        e.cyc = c;
        e.dut = d;
        e.sig = s;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic expect_range(input int lo, input int hi, input int d, input int s, input int v);
        for (int c = lo; c <= hi; c++) expect_at(c, d, s, v);
    endtask

    task automatic expect_reset();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 5; s++) expect_at(-1, d, s, 0);
    endtask

    // Counter/pipeline expectations for both instances in cycle k
    task automatic expect_counters(input int k);
        expect_at(k, 0, SIG_ROM, k % 64);
        expect_at(k, 0, SIG_ADDR, (k >= 2) ? (k - 2) % 64 : 0);
        expect_at(k, 0, SIG_SWP, (k > 0 && k % 64 == 0) ? 1 : 0);
        expect_at(k, 1, SIG_ROM, k % 8);
        expect_at(k, 1, SIG_ADDR, (k >= 2) ? (k - 2) % 8 : 0);
        expect_at(k, 1, SIG_SWP, (k > 0 && k % 8 == 0) ? 1 : 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus64.adc_valid = 1'b0;
        bus64.adc_bits  = '0;
        bus8.adc_valid  = 1'b0;
        bus8.adc_bits   = '0;
        expect_reset();
        repeat (3) @(posedge clk);

        n_vec++;
        if (bus64.rom_addr != '0) begin
            n_bad++;
            $display("FAIL t64.rom_addr in reset actual=%0d required=0", bus64.rom_addr);
        end
        n_vec++;
        if (bus64.buffer_bits != '0) begin
            n_bad++;
            $display("FAIL t64.buffer_bits in reset actual=%0d required=0", bus64.buffer_bits);
        end
        n_vec++;
        if (bus8.address != '0) begin
            n_bad++;
            $display("FAIL t8.address in reset actual=%0d required=0", bus8.address);
        end

        #1 rst_n = 1'b1;

        // Epoch 1 (64-tap): idle sweeps, single sample, overrun, last-tap strobe
        expect_range(1, 256, 0, SIG_BUF, 0);
        expect_at(257, 0, SIG_BUF, 100);
        expect_range(258, 320, 0, SIG_BUF, 0);
        expect_at(321, 0, SIG_BUF, 100);
        expect_range(322, 384, 0, SIG_BUF, 0);
        expect_at(385, 0, SIG_BUF, 7);
        expect_at(386, 0, SIG_BUF, 100);
        expect_range(387, 448, 0, SIG_BUF, 0);
        expect_at(449, 0, SIG_BUF, 55);
        expect_at(450, 0, SIG_BUF, 7);
        expect_at(451, 0, SIG_BUF, 100);
        expect_range(452, 512, 0, SIG_BUF, 0);
        expect_at(513, 0, SIG_BUF, 55);
        expect_at(514, 0, SIG_BUF, 7);
        expect_at(515, 0, SIG_BUF, 100);
        expect_range(516, 531, 0, SIG_BUF, 0);
        expect_range(1, 340, 0, SIG_OVR, 0);
        expect_at(341, 0, SIG_OVR, 1);
        expect_range(342, 531, 0, SIG_OVR, 0);
        expect_range(1, 531, 1, SIG_BUF, 0);
        expect_range(1, 531, 1, SIG_OVR, 0);

        for (int k = 0; k < 532; k++) begin
            expect_counters(k);
            bus64.adc_valid = 1'b1;
            case (k)
                195:     bus64.adc_bits = 12'sd100;
                330:     bus64.adc_bits = -12'sd5;
                340:     bus64.adc_bits = 12'sd7;
                447:     bus64.adc_bits = 12'sd55;
                515:     bus64.adc_bits = 12'sd99;
                default: bus64.adc_valid = 1'b0;
            endcase
            next_cycle();
        end

        // Reset mid-sweep (rom_addr 20, sample 99 pending)
        rst_n           = 1'b0;
        bus64.adc_valid = 1'b0;
        expect_reset();
        #1;

        n_vec++;
        if (bus64.rom_addr != '0) begin
            n_bad++;
            $display("FAIL t64.rom_addr after mid-sweep reset actual=%0d required=0", bus64.rom_addr);
        end
        n_vec++;
        if (bus64.address != '0) begin
            n_bad++;
            $display("FAIL t64.address after mid-sweep reset actual=%0d required=0", bus64.address);
        end
        n_vec++;
        if (bus64.sweep_start != 1'b0) begin
            n_bad++;
            $display("FAIL t64.sweep_start after mid-sweep reset actual=%0d required=0", bus64.sweep_start);
        end
        n_vec++;
        if (bus64.overrun != 1'b0) begin
            n_bad++;
            $display("FAIL t64.overrun after mid-sweep reset actual=%0d required=0", bus64.overrun);
        end

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Epoch 2: 64-tap restarts clean; 8-tap gets samples 1..8, one per sweep
        expect_range(1, 130, 0, SIG_BUF, 0);
        expect_range(1, 130, 0, SIG_OVR, 0);
        expect_range(1, 8, 1, SIG_BUF, 0);
        expect_at(9, 1, SIG_BUF, 1);
        for (int t = 0; t < 8; t++) expect_at(65 + t, 1, SIG_BUF, 8 - t);
        expect_range(1, 72, 1, SIG_OVR, 0);

        for (int k = 0; k <= 140; k++) begin
            expect_counters(k);
            if (k % 8 == 2 && k < 64) begin
                bus8.adc_valid = 1'b1;
                bus8.adc_bits  = 12'(k / 8 + 1);
            end else begin
                bus8.adc_valid = 1'b0;
            end
            next_cycle();
        end
        bus8.adc_valid = 1'b0;

        foreach (sb_q[i]) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s never_checked cyc=%0d required=%0d",
                     sig_name(sb_q[i].dut, sb_q[i].sig), sb_q[i].cyc, sb_q[i].val);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Upstream feeder for the FIR multiply-accumulate stage.
- Captures ADC samples into a circular delay line of 2^(Order_MSB+1) taps.
- Sweeps the tap index continuously, presenting coefficient ROM addresses, delayed samples x[n-k], and the tap address pipelined to the MAC's timing.
- Each sweep sees one consistent sample window; the MAC latches its result when the address wraps to 0.

Parameters:
- Order_MSB, 5, tap index MSB; TAPS = 2^(Order_MSB+1) (default 64).
- ADC_MSB, 11, ADC sample MSB (12-bit signed samples).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- adc_valid  input  1  one-cycle strobe: adc_bits holds a new sample.
- adc_bits  input  ADC_MSB+1  signed ADC sample.
- rom_addr  output  Order_MSB+1  coefficient ROM address (ROM is synchronous, 1-cycle read).
- buffer_bits  output  ADC_MSB+1  signed delayed sample x[n-k]; aligned with ROM data for rom_addr k of the previous cycle.
- address  output  Order_MSB+1  tap index for the MAC; equals rom_addr delayed 2 cycles.
- sweep_start  output  1  one-cycle pulse when rom_addr = 0.
- overrun  output  1  one-cycle pulse: a pending sample was overwritten before commit.

Behaviour:
- Reset values (async on rst_n low):
  - rom_addr, address, buffer_bits = 0; sweep_start, overrun = 0.
  - head = 0; pending flag = 0; all delay-line entries = 0.
- Tap counter:
  - rom_addr increments by 1 every cycle, free-running, wraps TAPS-1 -> 0.
  - No stall and no enable; one full sweep takes TAPS cycles.
- sweep_start: high exactly in cycles where rom_addr = 0.
- Sample capture:
  - On adc_valid, adc_bits goes into a pending register and the pending flag is set.
  - If adc_valid arrives while pending is already set (no commit yet): newest sample wins and overrun pulses for 1 cycle.
- Commit:
  - Happens in the cycle where rom_addr = TAPS-1 and pending = 1 (including a sample arriving that same cycle).
  - Writes the sample to mem[head+1 mod TAPS], sets head <= head+1 mod TAPS, clears pending.
  - adc_valid in the commit cycle is committed directly; it does not cause overrun.
- Read:
  - buffer_bits <= mem[(head - rom_addr) mod TAPS], registered, 1-cycle latency.
  - The read of the oldest tap (rom_addr = TAPS-1) targets the commit slot and must return the OLD contents (read-before-write).
- Consistency: head only changes at commit, so every sweep (rom_addr 0..TAPS-1) reads a single window: newest at k=0, oldest at k=TAPS-1.
- MAC alignment:
  - address = rom_addr delayed 2 cycles, matching 1 cycle of ROM/buffer read plus 1 cycle of MAC multiply register.
  - When address = 0 at the MAC, its product register holds tap 0 and its sum holds the complete previous sweep.
- Rates: at most one sample per sweep is accepted loss-free (TAPS clocks per sample minimum). Faster input drops samples and flags overrun.
- Reset mid-sweep: everything returns to reset state immediately; the first sweep after release starts at rom_addr = 0 on the first clock.
- Arithmetic: all index math is unsigned modulo TAPS via natural wrap of Order_MSB+1-bit vectors; samples pass through unmodified (no sign or width change).

Test Plan:
- Release reset, no adc_valid, 3 sweeps -> rom_addr counts 0..63 repeatedly; sweep_start every 64 cycles; buffer_bits = 0 throughout; address trails rom_addr by exactly 2 cycles.
- Order_MSB=2 (8 taps); adc_valid with 1..8 once per sweep -> the sweep after the 8th commit reads buffer_bits 8,7,6,5,4,3,2,1 for rom_addr 0..7.
- Single sample 100 at rom_addr=3 -> no change in the current sweep; next sweep reads 100 at k=0; the commit happens at rom_addr=TAPS-1 and the same-cycle oldest-tap read returns the old value (0).
- Two adc_valid (-5 then 7) within one sweep -> overrun pulses once on the second strobe; only 7 is committed; -5 never appears.
- adc_valid exactly at rom_addr=TAPS-1 -> committed that cycle; no overrun; visible at k=0 in the following sweep.
- Assert rst_n low mid-sweep at rom_addr=20 with pending set -> all outputs 0 immediately; pending discarded; after release rom_addr restarts at 0 and the delay line reads all zeros.
